umai_slv_arb: RTL and testbench
===============================

// Module: umai_slv_arb
// PURPOSE
// - Shares one UMAI slave port (one aib_top channel) between NumReq on-chip requesters.
// - Round-robin arbitration of write cmds (write data burst locked to winner) and read cmds.
// - Read data routed back in command order via a tag FIFO.
// - Sits between requester IPs and the aib_top i_umai_slv_* / o_umai_slv_* port of one channel, in the i_ip_clk domain.
// PARAMETERS
// - NumReq      4    number of requesters (2..8)
// - RdTagDepth  4    outstanding read cmds tracked (power of 2)
// PORTS
// - i_clk              in   1          ip clock (same clock as aib_top i_ip_clk)
// - i_rst              in   1          async active-high reset
// - i_req_wcmd_valid   in   NumReq     per-requester write cmd valid
// - o_req_wcmd_ready   out  NumReq     per-requester write cmd ready
// - i_req_wcmd_addr    in   32 x NumReq  write addr
// - i_req_wcmd_len     in   6 x NumReq   write beats-1
// - i_req_wvalid / o_req_wready  in/out  NumReq  write data handshake
// - i_req_wdata        in   512 x NumReq  write data
// - i_req_rcmd_valid / o_req_rcmd_ready  in/out  NumReq  read cmd handshake
// - i_req_rcmd_addr / i_req_rcmd_len     in  32/6 x NumReq  read addr, beats-1
// - o_req_rvalid / i_req_rready          out/in  NumReq  read data handshake
// - o_req_rdata        out  512        read data, broadcast to all requesters
// - o_umai_wcmd_valid/addr/len  out  1/32/6   to aib_top i_umai_slv_wcmd_*
// - i_umai_wcmd_ready  in   1
// - o_umai_wvalid/wdata out 1/512; i_umai_wready in 1
// - o_umai_rcmd_valid/addr/len  out  1/32/6;  i_umai_rcmd_ready in 1
// - i_umai_rvalid/rdata in 1/512;  o_umai_rready out 1
// BEHAVIOUR
// - Reset: all valid/ready outputs 0, addr/len/data 0, rr pointers 0, tag FIFO empty, write FSM W_IDLE.
// - Write FSM W_IDLE -> W_CMD -> W_DATA -> W_IDLE:
//   W_IDLE: rr pick among i_req_wcmd_valid, register gnt_id/addr/len, go W_CMD (1 cycle arb latency).
//   W_CMD: o_umai_wcmd_valid=1 from registers; on i_umai_wcmd_ready pulse o_req_wcmd_ready[gnt_id] same cycle, go W_DATA.
//   W_DATA: wvalid/wdata/wready muxed combinationally to/from gnt_id only; beat counter counts wvalid&wready;
//     after len+1 beats (len=63 -> 64 beats) back to W_IDLE; rr pointer = gnt_id+1 mod NumReq.
//   Next write arb cannot start before the last data beat completes; no cmd/data overlap.
// - Read path: rr pick among i_req_rcmd_valid gated by !tag_full; o_umai_rcmd_* combinational mux of
//   winner; grant held (pending flag) while o_umai_rcmd_valid & !i_umai_rcmd_ready; on handshake push
//   {id,len}, o_req_rcmd_ready[id]=1, pointer = id+1.
// - Read return: head tag selects o_req_rvalid[head.id]=i_umai_rvalid, o_umai_rready=i_req_rready[head.id];
//   beat counter; pop on beat len+1. Tag empty -> o_umai_rready=0, all o_req_rvalid=0.
// - Tag FIFO full: no rcmd grant. Push and pop same cycle: both happen, count unchanged; full
//   computed from registered count (no bypass of a full FIFO).
// - Only requesters with valid are eligible; single requester -> granted every time.
// - Requesters must hold valid+payload until ready (UMAI rule); no protocol checking here.
// - Reset mid-burst: FSM, counters, FIFO cleared immediately; in-flight beats dropped.
// STRUCTURE
// - umai_pkg: UmaiAddrW=32, UmaiLenW=6, UmaiDataW=512, typedef rd_tag_t {id, len}.
// - Sub-module umai_rr_arb (NumReq; req, advance, gnt_onehot, gnt_id) instantiated for wr and rd.
// - Tag FIFO inline (RdTagDepth regs + wr/rd pointers + count).
// TESTING
// - Req0,2 wcmd same cycle, len=0/3 -> req0 cmd+1 beat then req2 cmd+4 beats; no overlap.
// - All 4 reqs continuous rcmd len=0 -> grant order 0,1,2,3,0; rdata beats routed to same order.
// - i_umai_rcmd_ready held 0 for 5 cycles -> addr/len stable, grant unchanged.
// - 4 outstanding reads, 5th rcmd -> ready low until first return pops; same-cycle push/pop ok.
// - len=63 write -> exactly 64 beats then W_IDLE; wready backpressure every other cycle.
// - i_rst asserted in W_DATA beat 2 -> outputs 0 immediately, next write restarts from req0.

Source files
------------

// File: rtl/umai_pkg.sv
// Shared widths, write-FSM states and the read tag record for the UMAI slave arbiter.
package umai_pkg;

  localparam int UmaiAddrW = 32;
  localparam int UmaiLenW  = 6;
  localparam int UmaiDataW = 512;
  localparam int UmaiIdW   = 3;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_CMD  = 2'd1,
    W_DATA = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [UmaiIdW-1:0]  id;
    logic [UmaiLenW-1:0] len;
  } rd_tag_t;

endpackage

// File: rtl/umai_rr_arb.sv
// Round-robin arbiter: lowest index at or after the pointer wins; pointer moves past the
// winner when advance is raised.
module umai_rr_arb #(
  parameter int NumReq = 4,
  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              advance,
  output logic [NumReq-1:0] gnt_onehot,
  output logic [IdW-1:0]    gnt_id
);

  logic [IdW-1:0] ptr_r;
  logic [IdW-1:0] ptr_nxt_s;
  logic           found_s;
  int             idx_s;

  // Scan requesters starting at the pointer, first asserted one wins.
  always_comb begin
    gnt_id  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx_s = ((int'(ptr_r) + i) >= NumReq) ? (int'(ptr_r) + i - NumReq) : (int'(ptr_r) + i);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        gnt_id  = IdW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
    gnt_onehot = found_s ? (NumReq'(1) << gnt_id) : '0;
    ptr_nxt_s  = (gnt_id == IdW'(NumReq - 1)) ? '0 : (gnt_id + IdW'(1));
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/umai_slv_arb.sv
// Shares one UMAI slave channel between NumReq requesters: locked write bursts, round-robin
// read commands, read data steered back in command order by a tag FIFO.
module umai_slv_arb
  import umai_pkg::*;
#(
  parameter int NumReq     = 4,
  parameter int RdTagDepth = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NumReq-1:0]                   i_req_wcmd_valid,
  output logic [NumReq-1:0]                   o_req_wcmd_ready,
  input  logic [NumReq-1:0][UmaiAddrW-1:0]    i_req_wcmd_addr,
  input  logic [NumReq-1:0][UmaiLenW-1:0]     i_req_wcmd_len,
  input  logic [NumReq-1:0]                   i_req_wvalid,
  output logic [NumReq-1:0]                   o_req_wready,
  input  logic [NumReq-1:0][UmaiDataW-1:0]    i_req_wdata,
  input  logic [NumReq-1:0]                   i_req_rcmd_valid,
  output logic [NumReq-1:0]                   o_req_rcmd_ready,
  input  logic [NumReq-1:0][UmaiAddrW-1:0]    i_req_rcmd_addr,
  input  logic [NumReq-1:0][UmaiLenW-1:0]     i_req_rcmd_len,
  output logic [NumReq-1:0]                   o_req_rvalid,
  input  logic [NumReq-1:0]                   i_req_rready,
  output logic [UmaiDataW-1:0]                o_req_rdata,
  output logic                                o_umai_wcmd_valid,
  output logic [UmaiAddrW-1:0]                o_umai_wcmd_addr,
  output logic [UmaiLenW-1:0]                 o_umai_wcmd_len,
  input  logic                                i_umai_wcmd_ready,
  output logic                                o_umai_wvalid,
  output logic [UmaiDataW-1:0]                o_umai_wdata,
  input  logic                                i_umai_wready,
  output logic                                o_umai_rcmd_valid,
  output logic [UmaiAddrW-1:0]                o_umai_rcmd_addr,
  output logic [UmaiLenW-1:0]                 o_umai_rcmd_len,
  input  logic                                i_umai_rcmd_ready,
  input  logic                                i_umai_rvalid,
  input  logic [UmaiDataW-1:0]                i_umai_rdata,
  output logic                                o_umai_rready
);

  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW = (RdTagDepth > 1) ? $clog2(RdTagDepth) : 1;
  localparam int CntW = PtrW + 1;

  wr_state_e           state_r, nxt_state_s;
  logic [NumReq-1:0]   wr_req_s, wr_gnt_oh_s, wgnt_oh_s;
  logic [IdW-1:0]      wr_gnt_id_s, wgnt_id_r;
  logic                wr_pick_s, wbeat_hs_s, wlast_s;
  logic [UmaiAddrW-1:0] waddr_r;
  logic [UmaiLenW-1:0] wlen_r, wbeat_r;

  assign wr_req_s   = (state_r == W_IDLE) ? i_req_wcmd_valid : '0;
  assign wr_pick_s  = |wr_gnt_oh_s;
  assign wgnt_oh_s  = NumReq'(1) << wgnt_id_r;
  assign wbeat_hs_s = (state_r == W_DATA) && i_req_wvalid[wgnt_id_r] && i_umai_wready;
  assign wlast_s    = wbeat_hs_s && (wbeat_r == wlen_r);

  umai_rr_arb #(.NumReq(NumReq)) u_wr_arb (
    .clk        (i_clk),
    .rst        (i_rst),
    .req        (wr_req_s),
    .advance    (wr_pick_s),
    .gnt_onehot (wr_gnt_oh_s),
    .gnt_id     (wr_gnt_id_s)
  );

  // Write FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= W_IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Write FSM next state; a new arbitration only starts once the last beat has gone.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      W_IDLE:  nxt_state_s = wr_pick_s ? W_CMD : W_IDLE;
      W_CMD:   nxt_state_s = i_umai_wcmd_ready ? W_DATA : W_CMD;
      W_DATA:  nxt_state_s = wlast_s ? W_IDLE : W_DATA;
      default: nxt_state_s = W_IDLE;
    endcase
  end

  // Write FSM outputs: cmd from the latched grant, data muxed to the burst owner only.
  always_comb begin
    o_umai_wcmd_valid = 1'b0;
    o_umai_wcmd_addr  = '0;
    o_umai_wcmd_len   = '0;
    o_req_wcmd_ready  = '0;
    o_umai_wvalid     = 1'b0;
    o_umai_wdata      = '0;
    o_req_wready      = '0;
    case (state_r)
      W_IDLE: begin
        o_umai_wcmd_valid = 1'b0;
      end
      W_CMD: begin
        o_umai_wcmd_valid = 1'b1;
        o_umai_wcmd_addr  = waddr_r;
        o_umai_wcmd_len   = wlen_r;
        o_req_wcmd_ready  = i_umai_wcmd_ready ? wgnt_oh_s : '0;
      end
      W_DATA: begin
        o_umai_wvalid = i_req_wvalid[wgnt_id_r];
        o_umai_wdata  = i_req_wdata[wgnt_id_r];
        o_req_wready  = i_umai_wready ? wgnt_oh_s : '0;
      end
      default: begin
        o_umai_wvalid = 1'b0;
      end
    endcase
  end

  // Latched write grant and beat counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wgnt_id_r <= '0;
      waddr_r   <= '0;
      wlen_r    <= '0;
      wbeat_r   <= '0;
    end else if ((state_r == W_IDLE) && wr_pick_s) begin
      wgnt_id_r <= wr_gnt_id_s;
      waddr_r   <= i_req_wcmd_addr[wr_gnt_id_s];
      wlen_r    <= i_req_wcmd_len[wr_gnt_id_s];
      wbeat_r   <= '0;
    end else if (wbeat_hs_s) begin
      wbeat_r <= wlast_s ? '0 : (wbeat_r + UmaiLenW'(1));
    end else begin
      wbeat_r <= wbeat_r;
    end
  end

  logic [NumReq-1:0] rd_req_s, rd_gnt_oh_s, rsel_oh_s;
  logic [IdW-1:0]    rd_gnt_id_s, rd_pend_id_r;
  logic              rd_pend_r, rd_hs_s, rbeat_hs_s, push_s, pop_s;
  logic              tag_full_s, tag_empty_s;
  rd_tag_t           tag_mem_r [RdTagDepth];
  rd_tag_t           tag_head_s;
  logic [PtrW-1:0]   wptr_r, rptr_r;
  logic [CntW-1:0]   cnt_r;
  logic [UmaiLenW-1:0] rbeat_r;

  assign tag_full_s  = (cnt_r == CntW'(RdTagDepth));
  assign tag_empty_s = (cnt_r == CntW'(0));
  assign tag_head_s  = tag_mem_r[rptr_r];

  // A stalled command keeps its grant even if a higher-priority requester shows up.
  assign rd_req_s = rd_pend_r ? (NumReq'(1) << rd_pend_id_r)
                              : (i_req_rcmd_valid & {NumReq{!tag_full_s}});

  umai_rr_arb #(.NumReq(NumReq)) u_rd_arb (
    .clk        (i_clk),
    .rst        (i_rst),
    .req        (rd_req_s),
    .advance    (rd_hs_s),
    .gnt_onehot (rd_gnt_oh_s),
    .gnt_id     (rd_gnt_id_s)
  );

  assign o_umai_rcmd_valid = |rd_gnt_oh_s;
  assign o_umai_rcmd_addr  = o_umai_rcmd_valid ? i_req_rcmd_addr[rd_gnt_id_s] : '0;
  assign o_umai_rcmd_len   = o_umai_rcmd_valid ? i_req_rcmd_len[rd_gnt_id_s] : '0;
  assign rd_hs_s           = o_umai_rcmd_valid && i_umai_rcmd_ready;
  assign o_req_rcmd_ready  = rd_hs_s ? rd_gnt_oh_s : '0;
  assign push_s            = rd_hs_s;

  // Decode the head tag into a requester select.
  always_comb begin
    rsel_oh_s = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsel_oh_s[i] = (tag_head_s.id == UmaiIdW'(i));
    end
  end

  assign o_umai_rready = !tag_empty_s && (|(rsel_oh_s & i_req_rready));
  assign o_req_rvalid  = (!tag_empty_s && i_umai_rvalid) ? rsel_oh_s : '0;
  assign o_req_rdata   = i_umai_rdata;
  assign rbeat_hs_s    = i_umai_rvalid && o_umai_rready;
  assign pop_s         = rbeat_hs_s && (rbeat_r == tag_head_s.len);

  // Read grant hold flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_pend_r    <= 1'b0;
      rd_pend_id_r <= '0;
    end else begin
      rd_pend_r    <= o_umai_rcmd_valid && !i_umai_rcmd_ready;
      rd_pend_id_r <= rd_gnt_id_s;
    end
  end

  // Tag FIFO storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RdTagDepth; i++) begin
        tag_mem_r[i] <= '0;
      end
    end else if (push_s) begin
      tag_mem_r[wptr_r] <= '{id: UmaiIdW'(rd_gnt_id_s), len: o_umai_rcmd_len};
    end else begin
      tag_mem_r[wptr_r] <= tag_mem_r[wptr_r];
    end
  end

  // Tag FIFO pointers, occupancy and return beat counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      cnt_r   <= '0;
      rbeat_r <= '0;
    end else begin
      wptr_r  <= push_s ? (wptr_r + PtrW'(1)) : wptr_r;
      rptr_r  <= pop_s ? (rptr_r + PtrW'(1)) : rptr_r;
      rbeat_r <= pop_s ? '0 : (rbeat_hs_s ? (rbeat_r + UmaiLenW'(1)) : rbeat_r);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CntW'(1);
        2'b01:   cnt_r <= cnt_r - CntW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_umai_slv_arb.sv
// Scoreboard bench for umai_slv_arb: requester tasks drive commands, a monitor models the
// UMAI slave and checks every command and data handshake against queued expectations.
module tb_umai_slv_arb;
  import umai_pkg::*;

  localparam int N = 4;
  localparam int D = UmaiDataW;

  typedef struct { int id; logic [31:0] addr; int len; } cmd_t;
  typedef struct { int id; logic [D-1:0] data; } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]         i_req_wcmd_valid, o_req_wcmd_ready, i_req_wvalid, o_req_wready;
  logic [N-1:0][31:0]   i_req_wcmd_addr, i_req_rcmd_addr;
  logic [N-1:0][5:0]    i_req_wcmd_len, i_req_rcmd_len;
  logic [N-1:0][D-1:0]  i_req_wdata;
  logic [N-1:0]         i_req_rcmd_valid, o_req_rcmd_ready, o_req_rvalid, i_req_rready;
  logic [D-1:0]         o_req_rdata, o_umai_wdata, i_umai_rdata;
  logic                 o_umai_wcmd_valid, i_umai_wcmd_ready, o_umai_wvalid, i_umai_wready;
  logic [31:0]          o_umai_wcmd_addr, o_umai_rcmd_addr;
  logic [5:0]           o_umai_wcmd_len, o_umai_rcmd_len;
  logic                 o_umai_rcmd_valid, i_umai_rcmd_ready, i_umai_rvalid, o_umai_rready;

  umai_slv_arb #(.NumReq(N), .RdTagDepth(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_wcmd_valid(i_req_wcmd_valid), .o_req_wcmd_ready(o_req_wcmd_ready),
    .i_req_wcmd_addr(i_req_wcmd_addr), .i_req_wcmd_len(i_req_wcmd_len),
    .i_req_wvalid(i_req_wvalid), .o_req_wready(o_req_wready), .i_req_wdata(i_req_wdata),
    .i_req_rcmd_valid(i_req_rcmd_valid), .o_req_rcmd_ready(o_req_rcmd_ready),
    .i_req_rcmd_addr(i_req_rcmd_addr), .i_req_rcmd_len(i_req_rcmd_len),
    .o_req_rvalid(o_req_rvalid), .i_req_rready(i_req_rready), .o_req_rdata(o_req_rdata),
    .o_umai_wcmd_valid(o_umai_wcmd_valid), .o_umai_wcmd_addr(o_umai_wcmd_addr),
    .o_umai_wcmd_len(o_umai_wcmd_len), .i_umai_wcmd_ready(i_umai_wcmd_ready),
    .o_umai_wvalid(o_umai_wvalid), .o_umai_wdata(o_umai_wdata), .i_umai_wready(i_umai_wready),
    .o_umai_rcmd_valid(o_umai_rcmd_valid), .o_umai_rcmd_addr(o_umai_rcmd_addr),
    .o_umai_rcmd_len(o_umai_rcmd_len), .i_umai_rcmd_ready(i_umai_rcmd_ready),
    .i_umai_rvalid(i_umai_rvalid), .i_umai_rdata(i_umai_rdata), .o_umai_rready(o_umai_rready)
  );

  int checks = 0;
  int failures = 0;
  cmd_t  wcmd_q[$], rcmd_q[$];
  beat_t wdat_q[$], rdat_q[$];
  logic [D-1:0] slv_q[$];
  logic [D-1:0] dummy;
  bit slv_en = 1'b0, wbp = 1'b0, abort = 1'b0, r_hs_prev = 1'b0;
  int rcmd_hs_cnt = 0, wbeat_cnt = 0;

  function automatic logic [D-1:0] wpat(int id, logic [31:0] addr, int beat);
    logic [D-1:0] v;
    v = '0;
    v[31:0] = addr; v[39:32] = 8'(id); v[47:40] = 8'(beat);
    v[D-1 -: 32] = addr ^ 32'hDEAD_BEEF;
    return v;
  endfunction

  function automatic logic [D-1:0] rpat(logic [31:0] addr, int beat);
    logic [D-1:0] v;
    v = '0;
    v[31:0] = addr; v[47:40] = 8'(beat);
    v[D-1 -: 32] = addr ^ 32'h5A5A_0F0F;
    return v;
  endfunction

  function automatic logic [N-1:0] oh(int id);
    return N'(1) << id;
  endfunction

  function automatic cmd_t mk(int id, logic [31:0] addr, int len);
    cmd_t c;
    c.id = id; c.addr = addr; c.len = len;
    return c;
  endfunction

  // UMAI slave model plus scoreboard monitor; drives at negedge, samples 1 time unit later.
  initial begin : monitor
    cmd_t c;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) slv_q.delete();
      else if (r_hs_prev && slv_q.size() > 0) dummy = slv_q.pop_front();
      i_umai_rvalid = slv_en && (slv_q.size() > 0);
      i_umai_rdata  = (slv_q.size() > 0) ? slv_q[0] : '0;
      i_umai_wready = wbp ? ~i_umai_wready : 1'b1;
      #1;
      r_hs_prev = 1'b0;
      if (!rst) begin
        if (o_umai_wcmd_valid && i_umai_wcmd_ready) begin
          checks++;
          if (wcmd_q.size() == 0) begin
            failures++; $display("FAIL wcmd_unexpected: got addr %0h, required no cmd", o_umai_wcmd_addr);
          end else begin
            c = wcmd_q.pop_front();
            if ({o_umai_wcmd_addr, o_umai_wcmd_len} !== {c.addr, 6'(c.len)}) begin
              failures++; $display("FAIL wcmd_addr_len: got %0h/%0d, required %0h/%0d", o_umai_wcmd_addr, o_umai_wcmd_len, c.addr, c.len);
            end
            checks++;
            if (o_req_wcmd_ready !== oh(c.id)) begin
              failures++; $display("FAIL wcmd_ready: got %b, required %b", o_req_wcmd_ready, oh(c.id));
            end
            for (int k = 0; k <= c.len; k++) wdat_q.push_back('{c.id, wpat(c.id, c.addr, k)});
          end
        end
        if (o_umai_wvalid && i_umai_wready) begin
          wbeat_cnt++;
          checks++;
          if (wdat_q.size() == 0) begin
            failures++; $display("FAIL wbeat_unexpected: got data %0h", o_umai_wdata[47:0]);
          end else begin
            b = wdat_q.pop_front();
            if (o_umai_wdata !== b.data || o_req_wready !== oh(b.id) || o_umai_wcmd_valid !== 1'b0) begin
              failures++; $display("FAIL wbeat: got data %0h wready %b cmdv %b, required data %0h wready %b cmdv 0",
                                   o_umai_wdata[47:0], o_req_wready, o_umai_wcmd_valid, b.data[47:0], oh(b.id));
            end
          end
        end
        if (o_umai_rcmd_valid && i_umai_rcmd_ready) begin
          rcmd_hs_cnt++;
          checks++;
          if (rcmd_q.size() == 0) begin
            failures++; $display("FAIL rcmd_unexpected: got addr %0h", o_umai_rcmd_addr);
          end else begin
            c = rcmd_q.pop_front();
            if ({o_umai_rcmd_addr, o_umai_rcmd_len, o_req_rcmd_ready} !== {c.addr, 6'(c.len), oh(c.id)}) begin
              failures++; $display("FAIL rcmd: got %0h/%0d/%b, required %0h/%0d/%b", o_umai_rcmd_addr, o_umai_rcmd_len,
                                   o_req_rcmd_ready, c.addr, c.len, oh(c.id));
            end
            for (int k = 0; k <= int'(o_umai_rcmd_len); k++) slv_q.push_back(rpat(o_umai_rcmd_addr, k));
            for (int k = 0; k <= c.len; k++) rdat_q.push_back('{c.id, rpat(c.addr, k)});
          end
        end
        if (i_umai_rvalid && o_umai_rready) begin
          r_hs_prev = 1'b1;
          checks++;
          if (rdat_q.size() == 0) begin
            failures++; $display("FAIL rbeat_unexpected: got rvalid %b", o_req_rvalid);
          end else begin
            b = rdat_q.pop_front();
            if (o_req_rdata !== b.data || o_req_rvalid !== oh(b.id)) begin
              failures++; $display("FAIL rbeat: got data %0h rvalid %b, required data %0h rvalid %b",
                                   o_req_rdata[47:0], o_req_rvalid, b.data[47:0], oh(b.id));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wr_req(int id, logic [31:0] addr, int len);
    bit ok;
    @(negedge clk);
    i_req_wcmd_valid[id] = 1'b1; i_req_wcmd_addr[id] = addr; i_req_wcmd_len[id] = 6'(len);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok && !abort; t++) begin
      #1; ok = o_req_wcmd_ready[id]; @(negedge clk);
    end
    i_req_wcmd_valid[id] = 1'b0;
    if (!abort) begin
      checks++;
      if (!ok) begin failures++; $display("FAIL wcmd_timeout: req %0d got no ready, required ready", id); end
    end
    for (int b = 0; b <= len && ok && !abort; b++) begin
      i_req_wvalid[id] = 1'b1; i_req_wdata[id] = wpat(id, addr, b);
      ok = 1'b0;
      for (int t = 0; t < 300 && !ok && !abort; t++) begin
        #1; ok = o_req_wready[id]; @(negedge clk);
      end
      if (!ok && !abort) begin
        checks++; failures++; $display("FAIL wbeat_timeout: req %0d beat %0d got no wready, required wready", id, b);
      end
    end
    i_req_wvalid[id] = 1'b0;
  endtask

  task automatic rd_req(int id, logic [31:0] addr, int len);
    bit ok;
    @(negedge clk);
    i_req_rcmd_valid[id] = 1'b1; i_req_rcmd_addr[id] = addr; i_req_rcmd_len[id] = 6'(len);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1; ok = o_req_rcmd_ready[id]; @(negedge clk);
    end
    i_req_rcmd_valid[id] = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL rcmd_timeout: req %0d got no ready, required ready", id); end
  endtask

  task automatic release_reset();
    i_req_wcmd_valid = '0; i_req_wvalid = '0; i_req_rcmd_valid = '0;
    wcmd_q.delete(); wdat_q.delete(); rcmd_q.delete(); rdat_q.delete();
    rcmd_hs_cnt = 0; wbeat_cnt = 0; abort = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (wcmd_q.size() + wdat_q.size() + rcmd_q.size() + rdat_q.size()) > 0; t++)
      @(negedge clk);
    checks++;
    if ((wcmd_q.size() + wdat_q.size() + rcmd_q.size() + rdat_q.size()) != 0) begin
      failures++; $display("FAIL drain: %0d/%0d/%0d/%0d entries left, required 0/0/0/0",
                           wcmd_q.size(), wdat_q.size(), rcmd_q.size(), rdat_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_wcmd_valid = '0; i_req_wvalid = '0; i_req_rcmd_valid = '0; i_req_rready = '1;
    i_req_wcmd_addr = '0; i_req_wcmd_len = '0; i_req_wdata = '0;
    i_req_rcmd_addr = '0; i_req_rcmd_len = '0;
    i_umai_wcmd_ready = 1'b1; i_umai_rcmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({o_umai_wcmd_valid, o_umai_wcmd_addr, o_umai_wcmd_len, o_umai_wvalid} !== '0) begin
      failures++; $display("FAIL reset_wr: got %b/%0h/%0d/%b, required all 0", o_umai_wcmd_valid, o_umai_wcmd_addr, o_umai_wcmd_len, o_umai_wvalid);
    end
    checks++;
    if ({o_umai_rcmd_valid, o_umai_rcmd_addr, o_umai_rcmd_len, o_umai_rready} !== '0) begin
      failures++; $display("FAIL reset_rd: got %b/%0h/%0d/%b, required all 0", o_umai_rcmd_valid, o_umai_rcmd_addr, o_umai_rcmd_len, o_umai_rready);
    end
    checks++;
    if ({o_req_wcmd_ready, o_req_wready, o_req_rcmd_ready, o_req_rvalid} !== '0) begin
      failures++; $display("FAIL reset_req: got %b %b %b %b, required all 0", o_req_wcmd_ready, o_req_wready, o_req_rcmd_ready, o_req_rvalid);
    end
    release_reset();
  endtask

  task automatic test_wr_two();
    apply_reset();
    wcmd_q.push_back(mk(0, 32'h0000_1000, 0));
    wcmd_q.push_back(mk(2, 32'h0000_2000, 3));
    fork
      wr_req(0, 32'h0000_1000, 0);
      wr_req(2, 32'h0000_2000, 3);
    join
    drain();
  endtask

  task automatic test_rd_rr();
    apply_reset();
    slv_en = 1'b1;
    rcmd_q.push_back(mk(0, 32'h0001_0000, 0));
    rcmd_q.push_back(mk(1, 32'h0001_0100, 0));
    rcmd_q.push_back(mk(2, 32'h0001_0200, 0));
    rcmd_q.push_back(mk(3, 32'h0001_0300, 0));
    rcmd_q.push_back(mk(0, 32'h0001_0004, 0));
    fork
      begin rd_req(0, 32'h0001_0000, 0); rd_req(0, 32'h0001_0004, 0); end
      rd_req(1, 32'h0001_0100, 0);
      rd_req(2, 32'h0001_0200, 0);
      rd_req(3, 32'h0001_0300, 0);
    join
    drain();
  endtask

  task automatic test_rd_stall();
    apply_reset();
    slv_en = 1'b1;
    i_umai_rcmd_ready = 1'b0;
    rcmd_q.push_back(mk(1, 32'h0002_0100, 2));
    rcmd_q.push_back(mk(0, 32'h0002_0000, 1));
    fork
      rd_req(1, 32'h0002_0100, 2);
      begin repeat (2) @(negedge clk); rd_req(0, 32'h0002_0000, 1); end
      begin
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
          #1;
          checks++;
          if ({o_umai_rcmd_valid, o_umai_rcmd_addr, o_umai_rcmd_len, o_req_rcmd_ready} !== {1'b1, 32'h0002_0100, 6'd2, 4'b0000}) begin
            failures++; $display("FAIL rcmd_stall cyc %0d: got %b/%0h/%0d/%b, required 1/20100/2/0000", c,
                                 o_umai_rcmd_valid, o_umai_rcmd_addr, o_umai_rcmd_len, o_req_rcmd_ready);
          end
          @(negedge clk);
        end
        i_umai_rcmd_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_rd_full();
    apply_reset();
    slv_en = 1'b0;
    rcmd_q.push_back(mk(3, 32'h0003_0000, 1));
    for (int k = 1; k < 5; k++) rcmd_q.push_back(mk(3, 32'h0003_0000 + 32'(k * 16), 0));
    fork
      begin
        rd_req(3, 32'h0003_0000, 1);
        for (int k = 1; k < 5; k++) rd_req(3, 32'h0003_0000 + 32'(k * 16), 0);
      end
      begin
        for (int t = 0; t < 100 && rcmd_hs_cnt < 4; t++) @(negedge clk);
        checks++;
        if (rcmd_hs_cnt != 4) begin failures++; $display("FAIL full_fill: got %0d cmds, required 4", rcmd_hs_cnt); end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
          #1;
          checks++;
          if ({o_umai_rcmd_valid, o_req_rcmd_ready} !== 5'b0) begin
            failures++; $display("FAIL full_block cyc %0d: got rcmd_valid %b ready %b, required 0 0000", c, o_umai_rcmd_valid, o_req_rcmd_ready);
          end
          @(negedge clk);
        end
        slv_en = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_wr_long();
    apply_reset();
    wbp = 1'b1;
    wcmd_q.push_back(mk(1, 32'h0004_0000, 63));
    wr_req(1, 32'h0004_0000, 63);
    checks++;
    if (wbeat_cnt != 64) begin failures++; $display("FAIL long_beats: got %0d beats, required 64", wbeat_cnt); end
    wbp = 1'b0;
    wcmd_q.push_back(mk(2, 32'h0004_1000, 0));
    wr_req(2, 32'h0004_1000, 0);
    drain();
  endtask

  task automatic test_rst_mid();
    apply_reset();
    wcmd_q.push_back(mk(0, 32'h0005_0000, 3));
    fork
      wr_req(0, 32'h0005_0000, 3);
      begin
        for (int t = 0; t < 100 && wbeat_cnt < 2; t++) begin @(negedge clk); #2; end
        @(negedge clk);
        rst = 1'b1; abort = 1'b1;
        #1;
        checks++;
        if ({o_umai_wvalid, o_req_wready, o_umai_wcmd_valid, o_umai_wdata} !== '0) begin
          failures++; $display("FAIL rst_mid: got wvalid %b wready %b cmdv %b, required all 0", o_umai_wvalid, o_req_wready, o_umai_wcmd_valid);
        end
      end
    join
    release_reset();
    wcmd_q.push_back(mk(0, 32'h0005_1000, 0));
    wcmd_q.push_back(mk(1, 32'h0005_2000, 1));
    fork
      wr_req(1, 32'h0005_2000, 1);
      wr_req(0, 32'h0005_1000, 0);
    join
    drain();
  endtask

  initial begin
    i_umai_rvalid = 1'b0; i_umai_rdata = '0; i_umai_wready = 1'b1;
    test_reset();
    test_wr_two();
    test_rd_rr();
    test_rd_stall();
    test_rd_full();
    test_wr_long();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
